// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: byte-stream interface between uart_rx, the receive FIFO and its consumer.
// Revision: 1.0
`default_nettype none

interface uart_rx_fifo_if #(
  parameter int ADDR_W = 4
);
  logic [7:0]      rx_data;
  logic            rx_ready;
  logic            rx_error;
  logic            clear;
  logic [7:0]      out_data;
  logic            out_valid;
  logic            out_ready;
  logic [ADDR_W:0] level;
  logic            full;
  logic            overflow;
  logic            frame_err;

  modport master (
    output rx_data, rx_ready, rx_error, clear, out_ready,
    input  out_data, out_valid, level, full, overflow, frame_err
  );

  modport slave (
    input  rx_data, rx_ready, rx_error, clear, out_ready,
    output out_data, out_valid, level, full, overflow, frame_err
  );
endinterface

`default_nettype wire

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: first-word-fall-through receive FIFO with sticky overflow/framing status.
// Revision: 1.0
`default_nettype none

module uart_rx_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  uart_rx_fifo_if.slave bus
);

  localparam logic [ADDR_W:0] C_DEPTH = (ADDR_W+1)'(DEPTH);

  logic [7:0]        r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_level;
  logic              r_overflow;
  logic              r_frame_err;

  logic w_valid;
  logic w_full;
  logic w_pop;
  logic w_push;

  assign w_valid = (r_level != '0);
  assign w_full  = (r_level == C_DEPTH);
  assign w_pop   = w_valid & bus.out_ready;
  // A pop frees a slot in the same edge, so a full FIFO can still accept.
  assign w_push  = bus.rx_ready & (~w_full | w_pop);

  always_ff @(posedge clk) begin
    if (reset_n && !bus.clear && w_push) begin
      r_mem[r_wr_ptr] <= bus.rx_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
      r_overflow  <= 1'b0;
      r_frame_err <= 1'b0;
    end else if (bus.clear) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
      r_overflow  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
      if (bus.rx_ready && !w_push) begin
        r_overflow <= 1'b1;
      end
      if (bus.rx_error) begin
        r_frame_err <= 1'b1;
      end
    end
  end

  assign bus.out_valid = w_valid;
  assign bus.full      = w_full;
  assign bus.level     = r_level;
  assign bus.overflow  = r_overflow;
  assign bus.frame_err = r_frame_err;
  assign bus.out_data  = w_valid ? r_mem[r_rd_ptr] : 8'h00;

endmodule

`default_nettype wire
